// File: rtl/approx_mul_pkg.sv
// Shared constants, types and helpers for the approximate multiply-accumulate datapath.
// Imported by the accumulate stage and its saturating adder.
package approx_mul_pkg;

    localparam int DEF_PROD_W = 11;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/approx_sat_add.sv
// Unsigned saturating adder: acc + zero-extended prod, clamped to ACC_W bits.
// The ovf output flags that the clamp was applied.
module approx_sat_add
    import approx_mul_pkg::*;
#(
    parameter int ACC_W  = 14,
    parameter int PROD_W = DEF_PROD_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam int SW = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    logic [SW-1:0] nxt;

    // wide add, then clamp to all-ones when any bit above ACC_W is set
    always_comb begin
        nxt = SW'(acc) + SW'(prod);
        ovf = |nxt[SW-1:ACC_W];
        sum = ovf ? '1 : nxt[ACC_W-1:0];
    end

endmodule

// File: rtl/approx_dot_acc.sv
// Groups the approximate product stream into sums of up to LEN beats.
// Each finished group is presented through a one-entry valid/ready output register.
module approx_dot_acc
    import approx_mul_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int LEN    = 8,
    parameter int ACC_W  = 14,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf
);

    if (CNT_W < clog2(LEN) + 1 || LEN < 2) begin : g_bad_cfg
        $error("approx_dot_acc: CNT_W too small or LEN < 2");
    end

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic [ACC_W-1:0] sum;
    logic             sum_ovf;
    logic             take;
    logic             done;

    approx_sat_add #(
        .ACC_W (ACC_W),
        .PROD_W(PROD_W)
    ) u_add (
        .acc (acc),
        .prod(in_prod),
        .sum (sum),
        .ovf (sum_ovf)
    );

    assign in_ready = !out_valid || out_ready;
    assign take     = in_valid && in_ready && !clear;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign done     = take && (in_last || cnt_inc == CNT_W'(LEN));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: open a group on the first beat, close it on completion or clear
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (take && !done) state_nxt = ACCUM;
            ACCUM: if (done)          state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // running group sum, beat count and sticky saturation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clear || done) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (take) begin
            acc <= sum;
            cnt <= cnt_inc;
            ovf <= ovf | sum_ovf;
        end
    end

    // result register: load on completion, release on downstream accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else if (done) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_cnt   <= cnt_inc;
            out_ovf   <= ovf | sum_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_approx_dot_acc.sv
// Scoreboard bench for approx_dot_acc: a 14-bit and a 12-bit accumulator
// share one stimulus stream and are checked against a behavioural model.
module tb_approx_dot_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [10:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy_a, ov_a, of_a;
    logic [13:0] sum_a;
    logic [3:0]  cnt_a;
    logic        rdy_b, ov_b, of_b;
    logic [11:0] sum_b;
    logic [3:0]  cnt_b;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        int sa;
        int oa;
        int sb;
        int ob;
        int cnt;
    } exp_t;

    exp_t q[$];

    int m_sa = 0, m_oa = 0, m_sb = 0, m_ob = 0, m_cnt = 0;
    bit m_ov = 1'b0;

    always #5 clk = ~clk;

    approx_dot_acc #(.LEN(8), .ACC_W(14), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy_a),
        .in_prod(in_prod), .in_last(in_last),
        .out_valid(ov_a), .out_ready(out_ready),
        .out_sum(sum_a), .out_cnt(cnt_a), .out_ovf(of_a)
    );

    approx_dot_acc #(.LEN(8), .ACC_W(12), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy_b),
        .in_prod(in_prod), .in_last(in_last),
        .out_valid(ov_b), .out_ready(out_ready),
        .out_sum(sum_b), .out_cnt(cnt_b), .out_ovf(of_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic m_clr();
        m_sa = 0; m_oa = 0; m_sb = 0; m_ob = 0; m_cnt = 0;
    endtask

    // pending result and partial group are lost on reset
    always @(negedge rst_n) begin
        m_clr();
        m_ov = 1'b0;
        q.delete();
    end

    // reference model, advanced on each rising edge
    always @(posedge clk) begin
        if (rst_n) begin
            bit   rdy;
            bit   tk;
            exp_t e;
            rdy = !m_ov || out_ready;
            tk  = in_valid && rdy && !clear;
            if (m_ov && out_ready) m_ov = 1'b0;
            if (clear) begin
                m_clr();
            end else if (tk) begin
                m_sa += int'(in_prod);
                if (m_sa > 16383) begin m_sa = 16383; m_oa = 1; end
                m_sb += int'(in_prod);
                if (m_sb > 4095) begin m_sb = 4095; m_ob = 1; end
                m_cnt++;
                if (in_last || m_cnt == 8) begin
                    e.sa = m_sa; e.oa = m_oa;
                    e.sb = m_sb; e.ob = m_ob;
                    e.cnt = m_cnt;
                    q.push_back(e);
                    m_ov = 1'b1;
                    m_clr();
                end
            end
        end
    end

    // compare handshake signals every cycle, results on each output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            check("ov_a", ov_a, m_ov);
            check("ov_b", ov_b, m_ov);
            check("rdy_a", rdy_a, !m_ov || out_ready);
            check("rdy_b", rdy_b, !m_ov || out_ready);
            if (m_ov && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_empty", 0, 1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sum_a", sum_a, e.sa);
                    check("ovf_a", of_a, e.oa);
                    check("cnt_a", cnt_a, e.cnt);
                    check("sum_b", sum_b, e.sb);
                    check("ovf_b", of_b, e.ob);
                    check("cnt_b", cnt_b, e.cnt);
                end
            end
        end
    end

    task automatic send(input int p, input bit l, input bit c = 1'b0);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_prod  = 11'(p);
        in_last  = l;
        clear    = c;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = rdy_a;
            @(posedge clk);
            #1;
            if (ok || c) break;
        end
        if (!ok && !c) check("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_ov", ov_a, 0);
        check("rst_sum", sum_a, 0);
        check("rst_cnt", cnt_a, 0);
        check("rst_ovf", of_a, 0);
        check("rst_rdy", rdy_a, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        idle(2);
        check("por_ov", ov_a, 0);
        check("por_sum", sum_a, 0);
        check("por_cnt", cnt_a, 0);
        check("por_ovf", of_a, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("por_rdy", rdy_a, 1);
        @(posedge clk);
        #1;

        // full-length group without in_last
        for (int i = 0; i < 8; i++) send(2047, 0);
        idle(2);

        // early close, next group back to back
        send(100, 0);
        send(200, 0);
        send(300, 1);
        send(5, 0);
        send(6, 1);
        idle(2);

        // saturation in the narrow instance, then a clean group
        send(2047, 0);
        send(2047, 0);
        send(2047, 1);
        send(5, 0);
        send(6, 1);
        idle(2);

        // backpressure: group A held while group B waits
        out_ready = 1'b0;
        send(100, 0);
        send(200, 0);
        send(300, 1);
        in_valid = 1'b1;
        in_prod  = 11'd7;
        repeat (5) begin
            @(negedge clk);
            check("bp_rdy", rdy_a, 0);
            check("bp_sum", sum_a, 600);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(7, 0);
        send(8, 1);
        idle(2);

        // clear drops the concurrent beat and the partial group
        send(50, 0);
        send(60, 0);
        send(70, 0, 1'b1);
        send(9, 1);
        idle(2);

        // reset with a held result, then with a partial group
        out_ready = 1'b0;
        send(33, 1);
        idle(2);
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(1, 0);
        pulse_reset();
        for (int i = 0; i < 8; i++) send(1, 0);
        idle(3);
        check("drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
        $finish;
    end

endmodule
